intr_servicer: RTL and testbench

INTR_SERVICER -- requirements
Module: intr_servicer

---
 rtl/intr_servicer.sv | 77 +++++++
 tb/tb_intr_servicer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/intr_servicer.sv
// intr_servicer: services one granted interrupt at a time (IDLE->SERVICE->ACK->DROP); ports: pclk/prst, intr_valid_i/intr_to_service_i request, intr_serviced_o/intr_clear_o/abort_o pulses, busy_o/last_idx_o/idx_err_o status, cnt_sel_i/cnt_rdata_o counter read
module intr_servicer #(
  parameter int NUM_P_CTRLR = 16,
  parameter int IDX_W       = $clog2(NUM_P_CTRLR),
  parameter int SVC_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   pclk,
  input  logic                   prst,
  input  logic                   intr_valid_i,
  input  logic [NUM_P_CTRLR-1:0] intr_to_service_i,
  output logic                   intr_serviced_o,
  output logic [NUM_P_CTRLR-1:0] intr_clear_o,
  output logic                   busy_o,
  output logic [IDX_W-1:0]       last_idx_o,
  output logic                   abort_o,
  output logic                   idx_err_o,
  input  logic [IDX_W-1:0]       cnt_sel_i,
  output logic [CNT_W-1:0]       cnt_rdata_o
);
  typedef enum logic [1:0] {IDLE, SERVICE, ACK, DROP} state_t;
  state_t state;
  logic [7:0] dcnt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt [NUM_P_CTRLR];
  logic in_range;
  assign in_range = {32'd0, intr_to_service_i} < (NUM_P_CTRLR + 32)'(NUM_P_CTRLR);
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state           <= IDLE;
      dcnt            <= '0;
      idx             <= '0;
      intr_serviced_o <= 1'b0;
      intr_clear_o    <= '0;
      busy_o          <= 1'b0;
      last_idx_o      <= '0;
      abort_o         <= 1'b0;
      idx_err_o       <= 1'b0;
      cnt_rdata_o     <= '0;
      for (int i = 0; i < NUM_P_CTRLR; i++) cnt[i] <= '0;
    end else begin
      intr_serviced_o <= 1'b0;
      intr_clear_o    <= '0;
      abort_o         <= 1'b0;
      cnt_rdata_o     <= 32'(cnt_sel_i) < NUM_P_CTRLR ? cnt[cnt_sel_i] : '0;
      case (state)
        IDLE:
          if (intr_valid_i) begin
            if (in_range) begin
              idx    <= intr_to_service_i[IDX_W-1:0];
              dcnt   <= 8'(SVC_CYCLES - 1);
              state  <= SERVICE;
              busy_o <= 1'b1;
            end else idx_err_o <= 1'b1;
          end
        SERVICE:
          if (!intr_valid_i) begin
            abort_o <= 1'b1;
            state   <= IDLE;
            busy_o  <= 1'b0;
          end else if (dcnt == 8'd0) begin
            state           <= ACK;
            intr_serviced_o <= 1'b1;
            intr_clear_o    <= {{(NUM_P_CTRLR-1){1'b0}}, 1'b1} << idx;
            last_idx_o      <= idx;
            cnt[idx]        <= cnt[idx] == '1 ? cnt[idx] : cnt[idx] + 1'b1;
          end else dcnt <= dcnt - 8'd1;
        ACK: state <= DROP;
        DROP:
          if (!intr_valid_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_intr_servicer.sv
// tb_intr_servicer: scoreboard bench for intr_servicer with an 8-bit and a 2-bit counter instance
module tb_intr_servicer;
  localparam int SVC = 4;
  typedef struct {int idx; int due;} exp_t;
  logic pclk = 1'b0, prst = 1'b1, valid = 1'b0;
  logic [15:0] req = '0;
  logic [3:0] sel = '0;
  logic serviced, busy, abort_p, idx_err, serviced2, busy2, abort2, idx_err2;
  logic [15:0] clear, clear2;
  logic [3:0] last_idx, last_idx2;
  logic [7:0] rdata;
  logic [1:0] rdata2;
  exp_t q[$];
  exp_t e;
  int mcnt[16];
  int cyc = 0, checks = 0, errors = 0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc = cyc + 1;
  intr_servicer #(.NUM_P_CTRLR(16), .SVC_CYCLES(SVC), .CNT_W(8)) dut (
    .pclk(pclk), .prst(prst), .intr_valid_i(valid), .intr_to_service_i(req),
    .intr_serviced_o(serviced), .intr_clear_o(clear), .busy_o(busy), .last_idx_o(last_idx),
    .abort_o(abort_p), .idx_err_o(idx_err), .cnt_sel_i(sel), .cnt_rdata_o(rdata));
  intr_servicer #(.NUM_P_CTRLR(16), .SVC_CYCLES(SVC), .CNT_W(2)) dut2 (
    .pclk(pclk), .prst(prst), .intr_valid_i(valid), .intr_to_service_i(req),
    .intr_serviced_o(serviced2), .intr_clear_o(clear2), .busy_o(busy2), .last_idx_o(last_idx2),
    .abort_o(abort2), .idx_err_o(idx_err2), .cnt_sel_i(sel), .cnt_rdata_o(rdata2));
  always @(negedge pclk) begin
    if (serviced === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_serviced clear=%h last_idx=%0d expected no pulse", clear, last_idx);
      end else begin
        e = q.pop_front();
        if (clear !== (16'd1 << e.idx) || last_idx !== 4'(e.idx) || cyc !== e.due || clear2 !== clear || serviced2 !== 1'b1) begin
          errors++;
          $display("FAIL serviced_pulse clear=%h last_idx=%0d edge=%0d clear2=%h expected clear=%h last_idx=%0d edge=%0d",
                   clear, last_idx, cyc, clear2, 16'd1 << e.idx, e.idx, e.due);
        end
      end
    end
  end
  task automatic service(input int i);
    @(posedge pclk); #1;
    valid = 1'b1; req = 16'(i);
    q.push_back('{i, cyc + 1 + SVC});
    mcnt[i]++;
    repeat (SVC + 1) @(posedge pclk);
    @(negedge pclk); #1;
    checks++;
    if (q.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL service_%0d pending=%0d busy=%b expected pending=0 busy=1", i, q.size(), busy);
    end
    valid = 1'b0;
    q.delete();
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_to_idle_%0d busy=%b expected 0", i, busy);
    end
  endtask
  task automatic read_cnt(input int i, output logic [7:0] a, output logic [1:0] b);
    @(posedge pclk); #1;
    sel = 4'(i);
    @(posedge pclk); #1;
    a = rdata; b = rdata2;
  endtask
  task automatic test_reset;
    prst = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if ({serviced, clear, busy, abort_p, idx_err, last_idx, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_state serviced=%b clear=%h busy=%b abort=%b idx_err=%b last=%0d rdata=%0d expected all 0",
               serviced, clear, busy, abort_p, idx_err, last_idx, rdata);
    end
    prst = 1'b0;
  endtask
  task automatic test_request;
    logic [7:0] a;
    logic [1:0] b;
    service(5);
    checks++;
    if (last_idx !== 4'd5) begin
      errors++;
      $display("FAIL request_last_idx got=%0d expected 5", last_idx);
    end
    read_cnt(5, a, b);
    checks++;
    if (a !== 8'd1) begin
      errors++;
      $display("FAIL request_cnt5 got=%0d expected 1", a);
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] a;
    logic [1:0] b;
    service(3);
    read_cnt(3, a, b);
    checks++;
    if (a !== 8'(mcnt[3])) begin
      errors++;
      $display("FAIL b2b_cnt3 got=%0d expected %0d", a, mcnt[3]);
    end
    read_cnt(5, a, b);
    checks++;
    if (a !== 8'(mcnt[5])) begin
      errors++;
      $display("FAIL b2b_cnt5 got=%0d expected %0d", a, mcnt[5]);
    end
  endtask
  task automatic test_abort;
    logic [7:0] a;
    logic [1:0] b;
    @(posedge pclk); #1;
    valid = 1'b1; req = 16'd7;
    @(posedge pclk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_accept busy=%b expected 1", busy);
    end
    @(posedge pclk); #1;
    valid = 1'b0;
    @(posedge pclk); #1;
    checks++;
    if (abort_p !== 1'b1 || busy !== 1'b0 || serviced !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse abort=%b busy=%b serviced=%b expected 1 0 0", abort_p, busy, serviced);
    end
    @(posedge pclk); #1;
    checks++;
    if (abort_p !== 1'b0) begin
      errors++;
      $display("FAIL abort_one_cycle abort=%b expected 0", abort_p);
    end
    read_cnt(7, a, b);
    checks++;
    if (a !== 8'd0) begin
      errors++;
      $display("FAIL abort_cnt7 got=%0d expected 0", a);
    end
  endtask
  task automatic test_bad_index;
    @(posedge pclk); #1;
    valid = 1'b1; req = 16'd20;
    @(posedge pclk); #1;
    valid = 1'b0;
    checks++;
    if (idx_err !== 1'b1 || busy !== 1'b0 || serviced !== 1'b0 || clear !== '0) begin
      errors++;
      $display("FAIL bad_index idx_err=%b busy=%b serviced=%b clear=%h expected 1 0 0 0", idx_err, busy, serviced, clear);
    end
    service(2);
    checks++;
    if (idx_err !== 1'b1) begin
      errors++;
      $display("FAIL idx_err_sticky got=%b expected 1", idx_err);
    end
  endtask
  task automatic test_reset_mid;
    logic [7:0] a;
    logic [1:0] b;
    @(posedge pclk); #1;
    valid = 1'b1; req = 16'd9;
    repeat (2) @(posedge pclk);
    #2;
    prst = 1'b1;
    #1;
    checks++;
    if ({serviced, clear, busy, abort_p, idx_err, last_idx, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid serviced=%b clear=%h busy=%b abort=%b idx_err=%b last=%0d rdata=%0d expected all 0",
               serviced, clear, busy, abort_p, idx_err, last_idx, rdata);
    end
    valid = 1'b0;
    foreach (mcnt[i]) mcnt[i] = 0;
    @(posedge pclk); #2;
    prst = 1'b0;
    service(4);
    read_cnt(4, a, b);
    checks++;
    if (a !== 8'd1 || last_idx !== 4'd4) begin
      errors++;
      $display("FAIL reset_mid_resume cnt4=%0d last=%0d expected 1 4", a, last_idx);
    end
  endtask
  task automatic test_saturation;
    logic [7:0] a;
    logic [1:0] b;
    for (int k = 0; k < 4; k++) service(0);
    read_cnt(0, a, b);
    checks++;
    if (a !== 8'd4 || b !== 2'd3) begin
      errors++;
      $display("FAIL sat_four cnt8=%0d cnt2=%0d expected 4 3", a, b);
    end
    service(0);
    read_cnt(0, a, b);
    checks++;
    if (a !== 8'd5 || b !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold cnt8=%0d cnt2=%0d expected 5 3", a, b);
    end
  endtask
  initial begin
    foreach (mcnt[i]) mcnt[i] = 0;
    test_reset();
    test_request();
    test_back_to_back();
    test_abort();
    test_bad_index();
    test_reset_mid();
    test_saturation();
    repeat (3) @(posedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
